// File: rtl/f1_tick_delay.sv
//------------------------------------------------------------------------------
// Module   : f1_tick_delay
// Brief    : Tick prescaler and LFSR-randomised lights-out delay for the F1 FSM.
//            Define F1_FIXED_DELAY_EN to use FIXED_K instead of the LFSR for K.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module f1_tick_delay #(
  parameter int WIDTH   = 16,
  parameter int LFSR_W  = 7,
  parameter int FIXED_K = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  n,
  input  logic              cmd_seq,
  input  logic              cmd_delay,
  output logic              tick,
  output logic              time_out,
  output logic              busy,
  output logic [LFSR_W-1:0] lfsr_out,
  output logic [LFSR_W-1:0] delay_k
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEQ   = 2'd1,
    S_DELAY = 2'd2,
    S_FIRE  = 2'd3
  } state_t;

  // Maximal-length Fibonacci feedback masks; bit i set = stage i+1 tapped.
  function automatic logic [15:0] tap_table(input int w);
    case (w)
      3:       tap_table = 16'h0006;
      4:       tap_table = 16'h000C;
      5:       tap_table = 16'h0014;
      6:       tap_table = 16'h0030;
      7:       tap_table = 16'h0044;
      8:       tap_table = 16'h00B8;
      9:       tap_table = 16'h0110;
      10:      tap_table = 16'h0240;
      11:      tap_table = 16'h0500;
      12:      tap_table = 16'h0829;
      13:      tap_table = 16'h100D;
      14:      tap_table = 16'h2015;
      15:      tap_table = 16'h6000;
      default: tap_table = 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]       c_TAP_TABLE = tap_table(LFSR_W);
  localparam logic [LFSR_W-1:0] c_TAPS      = c_TAP_TABLE[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] c_K_ONE     = LFSR_W'(1);
  localparam logic [WIDTH-1:0]  c_CNT_ONE   = WIDTH'(1);

  if (LFSR_W < 3 || LFSR_W > 16 || FIXED_K < 1 || FIXED_K >= (1 << LFSR_W)) begin : g_bad_cfg
    $error("f1_tick_delay: unsupported LFSR_W or FIXED_K out of range");
  end

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [LFSR_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [LFSR_W-1:0] r_delay_k, w_delay_k_nxt;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_k;
  logic              r_dly_q;
  logic              w_rise;
  logic              w_cnt_zero;

`ifdef F1_FIXED_DELAY_EN
  assign w_k = LFSR_W'(FIXED_K);
`else
  assign w_k = r_lfsr;
`endif

  assign w_rise     = cmd_delay & ~r_dly_q;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dcnt_nxt    = r_dcnt;
    w_delay_k_nxt = r_delay_k;
    tick          = 1'b0;
    time_out      = 1'b0;
    busy          = (r_state != S_IDLE);

    // Prescaler runs only while ticks are being consumed; entry loads override below.
    if (r_state == S_SEQ || r_state == S_DELAY) begin
      tick      = w_cnt_zero;
      w_cnt_nxt = w_cnt_zero ? n : (r_cnt - c_CNT_ONE);
    end

    case (r_state)
      S_IDLE: begin
        if (cmd_seq) begin
          w_state_nxt = S_SEQ;
          w_cnt_nxt   = n;
        end else if (w_rise) begin
          w_state_nxt   = S_DELAY;
          w_cnt_nxt     = n;
          w_delay_k_nxt = w_k;
          w_dcnt_nxt    = w_k;
        end
      end
      S_SEQ: begin
        if (!cmd_seq) begin
          if (w_rise) begin
            w_state_nxt   = S_DELAY;
            w_cnt_nxt     = n;
            w_delay_k_nxt = w_k;
            w_dcnt_nxt    = w_k;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DELAY: begin
        if (cmd_seq) begin
          w_state_nxt = S_SEQ;
          w_cnt_nxt   = n;
        end else if (w_cnt_zero) begin
          if (r_dcnt == c_K_ONE) begin
            w_state_nxt = S_FIRE;
          end else begin
            w_dcnt_nxt = r_dcnt - c_K_ONE;
          end
        end
      end
      default: begin
        time_out    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dcnt    <= '0;
      r_delay_k <= '0;
      r_lfsr    <= c_K_ONE;
      r_dly_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_delay_k <= w_delay_k_nxt;
      r_lfsr    <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & c_TAPS)};
      r_dly_q   <= cmd_delay;
    end
  end

  assign lfsr_out = r_lfsr;
  assign delay_k  = r_delay_k;

endmodule

`default_nettype wire
